// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - word-stream input and instruction-RAM byte-write bundle
//
// Purpose: groups the host-side word handshake and the RAM-side byte write
// bus of the boot loader so they travel as one port.
// Signals:
//   in_valid  - word available on in_data (host -> loader)
//   in_ready  - loader can accept a word this cycle (loader -> host)
//   in_data   - 32-bit program word (host -> loader)
//   in_last   - final word of the program (host -> loader)
//   ram_we    - instruction RAM byte write enable (loader -> RAM)
//   ram_addr  - instruction RAM byte address (loader -> RAM)
//   ram_wdata - instruction RAM write byte (loader -> RAM)
// Modports: master = host/RAM environment, slave = loader.

interface imem_boot_loader_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams 32-bit program words into byte-wide instruction RAM, then releases core reset
//
// Purpose: accepts program words one at a time, writes each as four bytes
// (big-endian: bits [31:24] at byte 4k+0 ... bits [7:0] at 4k+3), and after
// the last word (or when the RAM is full) holds the core in reset for
// RELEASE_DELAY more cycles before letting it run.
// Ports:
//   clock       - single clock, rising edge
//   reset       - synchronous, active-high
//   bus         - imem_boot_loader_if.slave: word stream in, RAM byte writes out
//   core_reset  - drives the core reset; high until loading completes
//   load_done   - program loaded, core running
//   word_count  - number of words accepted (saturates at capacity)
//   overflow    - capacity reached before a word flagged in_last (sticky)
//   checksum    - only with LOADER_CHECKSUM_EN: 32-bit wrapping sum of accepted words
// Optional feature macro: LOADER_CHECKSUM_EN.

module imem_boot_loader #(
  parameter int ADDR_W        = 12,
  parameter int RELEASE_DELAY = 4
) (
  input  logic              clock,
  input  logic              reset,
  imem_boot_loader_if.slave bus,
  output logic              core_reset,
  output logic              load_done,
  output logic [ADDR_W-2:0] word_count,
  output logic              overflow
`ifdef LOADER_CHECKSUM_EN
  , output logic [31:0]     checksum
`endif
);

  // Full-capacity word count: 2**(ADDR_W-2) in an (ADDR_W-1)-bit field.
  localparam logic [ADDR_W-2:0] MAX_CNT = {1'b1, {(ADDR_W-2){1'b0}}};

  localparam int HOLD_W = (RELEASE_DELAY > 2) ? $clog2(RELEASE_DELAY) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT =
    HOLD_W'((RELEASE_DELAY > 0) ? RELEASE_DELAY - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_HOLD  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-3:0] word_idx_q, word_idx_d;
  logic [31:0]       data_q, data_d;
  logic              last_q, last_d;
  logic [ADDR_W-2:0] word_count_q, word_count_d;
  logic              overflow_q, overflow_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              core_reset_q, core_reset_d;
  logic              load_done_q, load_done_d;
  logic              handshake;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       checksum_q, checksum_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= 2'd0;
      word_idx_q   <= '0;
      data_q       <= 32'd0;
      last_q       <= 1'b0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      hold_cnt_q   <= '0;
      in_ready_q   <= 1'b1;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 8'd0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      data_q       <= data_d;
      last_q       <= last_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      hold_cnt_q   <= hold_cnt_d;
      in_ready_q   <= in_ready_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_idx_d   = word_idx_q;
    data_d       = data_q;
    last_d       = last_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    hold_cnt_d   = hold_cnt_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif
    // in_ready_q is a flop, so acceptance never depends combinationally on in_valid.
    handshake    = bus.in_valid & in_ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (handshake) begin
          state_d      = S_WRITE;
          data_d       = bus.in_data;
          last_d       = bus.in_last;
          // The pre-increment count is the index of the word being stored.
          word_idx_d   = word_count_q[ADDR_W-3:0];
          word_count_d = word_count_q + 1'b1;
          byte_idx_d   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          checksum_d   = checksum_q + bus.in_data;
`endif
        end
      end

      S_WRITE: begin
        if (byte_idx_q == 2'd3) begin
          // Capacity is checked before word_idx could ever wrap.
          if (last_q || (word_count_q == MAX_CNT)) begin
            overflow_d = overflow_q | ~last_q;
            if (RELEASE_DELAY == 0) begin
              state_d = S_RUN;
            end else begin
              state_d    = S_HOLD;
              hold_cnt_d = HOLD_INIT;
            end
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          byte_idx_d = byte_idx_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end

      S_RUN: begin
        state_d = S_RUN;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    in_ready_d   = (state_d == S_IDLE);
    ram_we_d     = (state_d == S_WRITE);
    core_reset_d = (state_d != S_RUN);
    load_done_d  = (state_d == S_RUN);

    if (state_d == S_WRITE) begin
      ram_addr_d = {word_idx_d, byte_idx_d};
      unique case (byte_idx_d)
        2'd0:    ram_wdata_d = data_d[31:24];
        2'd1:    ram_wdata_d = data_d[23:16];
        2'd2:    ram_wdata_d = data_d[15:8];
        default: ram_wdata_d = data_d[7:0];
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign core_reset    = core_reset_q;
  assign load_done     = load_done_q;
  assign word_count    = word_count_q;
  assign overflow      = overflow_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum      = checksum_q;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader

module tb_imem_boot_loader;

  localparam int AW_A = 12;
  localparam int RD_A = 4;
  localparam int AW_B = 4;
  localparam int RD_B = 2;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } in_vec_t;

  typedef struct {
    logic [AW_A-1:0] addr;
    logic [7:0]      data;
  } wr_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_boot_loader_if #(.ADDR_W(AW_A)) bus_a ();
  imem_boot_loader_if #(.ADDR_W(AW_B)) bus_b ();

  logic            core_reset_a, load_done_a, overflow_a;
  logic [AW_A-2:0] word_count_a;
  logic            core_reset_b, load_done_b, overflow_b;
  logic [AW_B-2:0] word_count_b;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]     checksum_a, checksum_b;
`endif

  imem_boot_loader #(.ADDR_W(AW_A), .RELEASE_DELAY(RD_A)) dut_a (
    .clock(clk), .reset(rst), .bus(bus_a.slave),
    .core_reset(core_reset_a), .load_done(load_done_a),
    .word_count(word_count_a), .overflow(overflow_a)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum_a)
`endif
  );

  imem_boot_loader #(.ADDR_W(AW_B), .RELEASE_DELAY(RD_B)) dut_b (
    .clock(clk), .reset(rst), .bus(bus_b.slave),
    .core_reset(core_reset_b), .load_done(load_done_b),
    .word_count(word_count_b), .overflow(overflow_b)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum_b)
`endif
  );

  // Observed RAM writes and the reference expectation.
  logic [AW_A-1:0] mon_addr_a[$];
  logic [7:0]      mon_data_a[$];
  logic [AW_A-1:0] exp_addr_a[$];
  logic [7:0]      exp_data_a[$];
  logic [AW_B-1:0] mon_addr_b[$];
  logic [7:0]      mon_data_b[$];
  logic [AW_B-1:0] exp_addr_b[$];
  logic [7:0]      exp_data_b[$];
  int              hs_cyc_a[$];
  int              last_wr_cyc_a = 0;
  int              overlap_a = 0;
  int              mcount_a = 0;
  logic [31:0]     msum_a = 32'd0;

  always @(negedge clk) begin
    if (bus_a.ram_we) begin
      mon_addr_a.push_back(bus_a.ram_addr);
      mon_data_a.push_back(bus_a.ram_wdata);
      last_wr_cyc_a = cyc;
    end
    if (bus_a.ram_we && bus_a.in_ready) overlap_a++;
    if (bus_b.ram_we) begin
      mon_addr_b.push_back(bus_b.ram_addr);
      mon_data_b.push_back(bus_b.ram_wdata);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = 32'd0; bus_a.in_last = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = 32'd0; bus_b.in_last = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    mon_addr_a.delete(); mon_data_a.delete();
    exp_addr_a.delete(); exp_data_a.delete();
    mon_addr_b.delete(); mon_data_b.delete();
    exp_addr_b.delete(); exp_data_b.delete();
    hs_cyc_a.delete();
    mcount_a = 0;
    msum_a   = 32'd0;
  endtask

  // Model of the RAM image: word k lands big-endian at bytes 4k..4k+3.
  task automatic model_word_a(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      exp_addr_a.push_back(AW_A'(mcount_a * 4 + b));
      exp_data_a.push_back(8'(w >> (8 * (3 - b))));
    end
    mcount_a++;
    msum_a = msum_a + w;
  endtask

  // Present one word; rnd adds idle cycles and garbage while not ready.
  task automatic send_a(input logic [31:0] w, input logic l, input bit rnd, output bit ok);
    int t;
    ok = 1'b0;
    t  = 0;
    if (!rnd) begin
      bus_a.in_valid = 1'b1; bus_a.in_data = w; bus_a.in_last = l;
    end
    while (t < 100) begin
      if (bus_a.in_ready && (!rnd || $urandom_range(3) != 0)) begin
        bus_a.in_valid = 1'b1; bus_a.in_data = w; bus_a.in_last = l;
        hs_cyc_a.push_back(cyc);
        model_word_a(w);
        ok = 1'b1;
        tick();
        break;
      end else if (rnd) begin
        bus_a.in_valid = bus_a.in_ready ? 1'b0 : 1'($urandom_range(1));
        bus_a.in_data  = $urandom;
        bus_a.in_last  = 1'($urandom_range(1));
      end
      tick();
      t++;
    end
    check("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_release_a(output int rel_cyc);
    int t;
    t = 0;
    while (core_reset_a && t < 300) begin
      tick();
      t++;
    end
    rel_cyc = cyc;
    check("release_timeout", 64'(core_reset_a), 64'd0);
  endtask

  task automatic cmp_writes_a(input string tag);
    check({tag, "_nwr"}, 64'(mon_addr_a.size()), 64'(exp_addr_a.size()));
    for (int i = 0; i < exp_addr_a.size() && i < mon_addr_a.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), {mon_addr_a[i], mon_data_a[i]},
            {exp_addr_a[i], exp_data_a[i]});
    mon_addr_a.delete(); mon_data_a.delete();
    exp_addr_a.delete(); exp_data_a.delete();
  endtask

  task automatic check_spacing(input string tag);
    for (int i = 1; i < hs_cyc_a.size(); i++)
      check($sformatf("%s_gap%0d", tag, i), 64'(hs_cyc_a[i] - hs_cyc_a[i-1]), 64'd5);
  endtask

  in_vec_t in_tab[3];
  wr_vec_t wr_tab[12];

  initial begin
    bit ok;
    int rel;
    int n;
    int t;
    int acc;
    logic [31:0] w;

    in_tab[0] = '{word: 32'h00000000, last: 1'b0};
    in_tab[1] = '{word: 32'h00500093, last: 1'b0};
    in_tab[2] = '{word: 32'hfe209ce3, last: 1'b1};
    wr_tab = '{'{12'd0, 8'h00}, '{12'd1, 8'h00}, '{12'd2, 8'h00}, '{12'd3, 8'h00},
               '{12'd4, 8'h00}, '{12'd5, 8'h50}, '{12'd6, 8'h00}, '{12'd7, 8'h93},
               '{12'd8, 8'hfe}, '{12'd9, 8'h20}, '{12'd10, 8'h9c}, '{12'd11, 8'he3}};

    // Reset state
    reset_all();
    check("rst_in_ready",   64'(bus_a.in_ready),  64'd1);
    check("rst_ram_we",     64'(bus_a.ram_we),    64'd0);
    check("rst_ram_addr",   64'(bus_a.ram_addr),  64'd0);
    check("rst_ram_wdata",  64'(bus_a.ram_wdata), 64'd0);
    check("rst_core_reset", 64'(core_reset_a),    64'd1);
    check("rst_load_done",  64'(load_done_a),     64'd0);
    check("rst_word_count", 64'(word_count_a),    64'd0);
    check("rst_overflow",   64'(overflow_a),      64'd0);

    // Directed program load from the table, in_valid held high
    for (int i = 0; i < 3; i++) send_a(in_tab[i].word, in_tab[i].last, 1'b0, ok);
    bus_a.in_valid = 1'b0;
    wait_release_a(rel);
    check("t1_release_delay", 64'(rel - last_wr_cyc_a), 64'(RD_A + 1));
    check("t1_load_done", 64'(load_done_a), 64'd1);
    check("t1_word_count", 64'(word_count_a), 64'd3);
    check("t1_overflow", 64'(overflow_a), 64'd0);
    check_spacing("t1");
    check("t1_nwr", 64'(mon_addr_a.size()), 64'd12);
    for (int i = 0; i < 12 && i < mon_addr_a.size(); i++)
      check($sformatf("t1_wr%0d", i), {mon_addr_a[i], mon_data_a[i]}, {wr_tab[i].addr, wr_tab[i].data});
    mon_addr_a.delete(); mon_data_a.delete();
    exp_addr_a.delete(); exp_data_a.delete();

    // RUN ignores input
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 32'hdeadbeef;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("run_ignore%0d", i), {bus_a.in_ready, bus_a.ram_we, load_done_a}, 3'b001);
    end
    bus_a.in_valid = 1'b0;
    check("run_no_writes", 64'(mon_addr_a.size()), 64'd0);

    // Four random words with in_valid held high: one acceptance every 5 cycles
    reset_all();
    for (int i = 0; i < 4; i++) send_a($urandom, 1'(i == 3), 1'b0, ok);
    bus_a.in_valid = 1'b0;
    wait_release_a(rel);
    check_spacing("t2");
    check("t2_word_count", 64'(word_count_a), 64'd4);
    cmp_writes_a("t2");

    // Randomized loads with idle gaps and garbage while not ready
    for (int it = 0; it < 6; it++) begin
      reset_all();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) send_a($urandom, 1'(i == n - 1), 1'b1, ok);
      bus_a.in_valid = 1'b0;
      wait_release_a(rel);
      check($sformatf("r%0d_word_count", it), 64'(word_count_a), 64'(mcount_a));
      check($sformatf("r%0d_overflow", it), 64'(overflow_a), 64'd0);
      check($sformatf("r%0d_release_delay", it), 64'(rel - last_wr_cyc_a), 64'(RD_A + 1));
`ifdef LOADER_CHECKSUM_EN
      check($sformatf("r%0d_checksum", it), 64'(checksum_a), 64'(msum_a));
`endif
      cmp_writes_a($sformatf("r%0d", it));
    end

`ifdef LOADER_CHECKSUM_EN
    reset_all();
    send_a(32'h00000001, 1'b0, 1'b0, ok);
    send_a(32'hffffffff, 1'b0, 1'b0, ok);
    send_a(32'h00000005, 1'b1, 1'b0, ok);
    bus_a.in_valid = 1'b0;
    wait_release_a(rel);
    check("cks_value", 64'(checksum_a), 64'h00000005);
`endif

    // Reset during the third byte write of the first word
    reset_all();
    send_a(32'h11223344, 1'b0, 1'b0, ok);
    bus_a.in_valid = 1'b0;
    t = 0;
    while (!(bus_a.ram_we && bus_a.ram_addr[1:0] == 2'd2) && t < 20) begin
      tick();
      t++;
    end
    check("mid_found_byte2", 64'(bus_a.ram_we && bus_a.ram_addr[1:0] == 2'd2), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_ram_we", 64'(bus_a.ram_we), 64'd0);
    check("mid_word_count", 64'(word_count_a), 64'd0);
    check("mid_core_reset", 64'(core_reset_a), 64'd1);
    check("mid_in_ready", 64'(bus_a.in_ready), 64'd1);
    rst = 1'b0;
    check("mid_nwr_before", 64'(mon_addr_a.size()), 64'd3);
    mon_addr_a.delete(); mon_data_a.delete();
    for (int i = 0; i < 10; i++) tick();
    check("mid_no_more_writes", 64'(mon_addr_a.size()), 64'd0);

    // Small RAM (4 words): five words without in_last
    reset_all();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      bus_b.in_valid = 1'b1; bus_b.in_data = w; bus_b.in_last = 1'b0;
      t = 0;
      while (!bus_b.in_ready && t < 20) begin
        tick();
        t++;
      end
      if (bus_b.in_ready) begin
        for (int b = 0; b < 4; b++) begin
          exp_addr_b.push_back(AW_B'(acc * 4 + b));
          exp_data_b.push_back(8'(w >> (8 * (3 - b))));
        end
        acc++;
        tick();
      end
    end
    bus_b.in_valid = 1'b0;
    check("ovf_accepted", 64'(acc), 64'd4);
    t = 0;
    while (core_reset_b && t < 50) begin
      tick();
      t++;
    end
    check("ovf_core_reset", 64'(core_reset_b), 64'd0);
    check("ovf_load_done", 64'(load_done_b), 64'd1);
    check("ovf_overflow", 64'(overflow_b), 64'd1);
    check("ovf_word_count", 64'(word_count_b), 64'd4);
    check("ovf_nwr", 64'(mon_addr_b.size()), 64'(exp_addr_b.size()));
    for (int i = 0; i < exp_addr_b.size() && i < mon_addr_b.size(); i++)
      check($sformatf("ovf_wr%0d", i), {mon_addr_b[i], mon_data_b[i]}, {exp_addr_b[i], exp_data_b[i]});

    check("we_ready_overlap", 64'(overlap_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
